// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle core's load/store/fetch port.
// One request at a time: accept in IDLE, burn WAIT_CYCLES wait states, perform a
// single-cycle word read or byte-strobed write, then hold the response until the
// initiator takes it.
// Optional feature macro: MEM_MISALIGN_ERR_EN (misaligned requests return an error
// and never touch the array).
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_wstrb,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    // Word-index width follows from the array depth.
    localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [3:0]         r_wait_cnt;
    logic [3:0]         w_wait_cnt_next;

    // Captured request; only the byte-address bits that select a word (plus the
    // two alignment bits) are kept, so higher address bits wrap naturally.
    logic               r_write;
    logic [ADDR_W+1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;

    logic [31:0]        r_rsp_rdata;
    logic               w_req_fire;
    logic               w_access;
    logic               w_misalign;
    logic [ADDR_W-1:0]  w_idx;

    logic [31:0]        r_mem [DEPTH_WORDS];

    assign w_idx      = r_addr[ADDR_W+1:2];
    assign w_req_fire = i_req_valid & o_req_ready;

`ifdef MEM_MISALIGN_ERR_EN
    logic r_rsp_err;
    logic w_unused_addr;

    assign w_misalign    = (r_addr[1:0] != 2'b00);
    assign o_rsp_err     = r_rsp_err;
    assign w_unused_addr = ^i_req_addr[31:ADDR_W+2];

    // Error flag is produced at the access step and held through the response.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rsp_err <= 1'b0;
        end else if (w_access) begin
            r_rsp_err <= w_misalign;
        end
    end
`else
    logic w_unused_addr;

    // Byte offset is ignored: every access goes to the containing aligned word.
    assign w_misalign    = 1'b0;
    assign o_rsp_err     = 1'b0;
    assign w_unused_addr = ^{i_req_addr[31:ADDR_W+2], r_addr[1:0]};
`endif

    assign o_rsp_rdata = r_rsp_rdata;

    // State and wait-counter registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= StIdle;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // Next-state logic and handshake outputs. The access fires in the WAIT cycle
    // where the counter has reached zero, so WAIT_CYCLES = 0 still spends exactly
    // one cycle in WAIT and the response appears one edge after acceptance.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_access        = 1'b0;
        o_req_ready     = 1'b0;
        o_rsp_valid     = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_state_next    = StWait;
                    w_wait_cnt_next = WaitInit;
                end
            end
            StWait: begin
                if (r_wait_cnt == 4'd0) begin
                    w_access     = 1'b1;
                    w_state_next = StResp;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - 4'd1;
                end
            end
            StResp: begin
                o_rsp_valid = 1'b1;
                // No accept in the handshake cycle; IDLE re-opens the next cycle.
                if (i_rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Request capture; fields are frozen until the next accept in IDLE.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
        end else if (w_req_fire) begin
            r_write <= i_req_write;
            r_addr  <= i_req_addr[ADDR_W+1:0];
            r_wdata <= i_req_wdata;
            r_wstrb <= i_req_wstrb;
        end
    end

    // Response data: array word for reads, zero for writes and rejected requests.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rsp_rdata <= 32'd0;
        end else if (w_access) begin
            if (r_write || w_misalign) begin
                r_rsp_rdata <= 32'd0;
            end else begin
                r_rsp_rdata <= r_mem[w_idx];
            end
        end
    end

    // Byte-strobed array write; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_access && r_write && !w_misalign) begin
            for (int n = 0; n < 4; n++) begin
                if (r_wstrb[n]) begin
                    r_mem[w_idx][8*n +: 8] <= r_wdata[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. Two instances share stimulus: one with two
// wait states and one with zero; sel routes the handshakes and observed outputs.
module tb_mem_responder;

    logic        clk;
    logic        rstn;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_ready;

    logic        ready_a, valid_a, err_a;
    logic [31:0] rdata_a;
    logic        ready_b, valid_b, err_b;
    logic [31:0] rdata_b;

    logic        obs_ready, obs_valid, obs_err;
    logic [31:0] obs_rdata;

    int checks;
    int errors;

    assign obs_ready = sel ? ready_b : ready_a;
    assign obs_valid = sel ? valid_b : valid_a;
    assign obs_err   = sel ? err_b   : err_a;
    assign obs_rdata = sel ? rdata_b : rdata_a;

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut_a (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_req_valid (req_valid & ~sel),
        .o_req_ready (ready_a),
        .i_req_write (req_write),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_req_wstrb (req_wstrb),
        .o_rsp_valid (valid_a),
        .i_rsp_ready (rsp_ready & ~sel),
        .o_rsp_rdata (rdata_a),
        .o_rsp_err   (err_a)
    );

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_b (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_req_valid (req_valid & sel),
        .o_req_ready (ready_b),
        .i_req_write (req_write),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_req_wstrb (req_wstrb),
        .o_rsp_valid (valid_b),
        .i_rsp_ready (rsp_ready & sel),
        .o_rsp_rdata (rdata_b),
        .o_rsp_err   (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, wait for the response, then take it with one handshake.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic err, output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'hBAD0BAD0;
        req_addr  = 32'hFFFF_FFFC;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!obs_valid && lat < 40);
        if (!obs_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: no response after %0d edges, required one", lat);
        end
        rdata = obs_rdata;
        err   = obs_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", obs_ready);
        end
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", obs_valid);
        end
        checks++;
        if (obs_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_rdata: got %h want 0", obs_rdata);
        end
        checks++;
        if (obs_err !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b want 0", obs_err);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: ready=%b valid=%b want 1/0", obs_ready, obs_valid);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        checks++;
        if (lat !== 3) begin
            errors++; $display("FAIL wr_latency: got %0d want 3", lat);
        end
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            errors++; $display("FAIL wr_rsp: rdata=%h err=%b want 0/0", rd, er);
        end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_data: got %h want deadbeef", rd);
        end
        checks++;
        if (lat !== 3) begin
            errors++; $display("FAIL rd_latency: got %0d want 3", lat);
        end
    endtask

    task automatic test_partial_write();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
        do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++; $display("FAIL partial_write: got %h want 11bb33dd", rd);
        end
        do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        checks++;
        if (lat !== 3 || rd !== 32'd0) begin
            errors++; $display("FAIL zero_strb_rsp: lat=%0d rdata=%h want 3/0", lat, rd);
        end
        do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++; $display("FAIL zero_strb_data: got %h want 11bb33dd", rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic        er;
        int          lat;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wstrb = 4'h0;
        @(posedge clk);
        #1;
        // Competing write held on the request channel while the response is stalled.
        req_write = 1'b1; req_wdata = 32'h0BADF00D; req_wstrb = 4'hF;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!obs_valid && lat < 40);
        checks++;
        if (!obs_valid) begin
            errors++; $display("FAIL bp_timeout: no response after %0d edges", lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs_valid !== 1'b1 || obs_ready !== 1'b0 || obs_rdata !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b ready=%b rdata=%h want 1/0/deadbeef",
                         i, obs_valid, obs_ready, obs_rdata);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++;
        if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: ready=%b valid=%b want 1/0", obs_ready, obs_valid);
        end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bp_ignored_req: got %h want deadbeef", rd);
        end
    endtask

    task automatic test_wrap_zero_wait();
        logic [31:0] rd;
        logic        er;
        int          lat;
        sel = 1'b1;
        do_req(1'b1, 32'h0, 32'h55, 4'hF, rd, er, lat);
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL zw_wr_latency: got %0d want 1", lat);
        end
        do_req(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h55) begin
            errors++; $display("FAIL wrap_data: got %h want 00000055", rd);
        end
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL zw_rd_latency: got %0d want 1", lat);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 32'h40, 32'h0, 4'hF, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40;
        req_wdata = 32'h12345678; req_wstrb = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: ready=%b valid=%b want 1/0", obs_ready, obs_valid);
        end
        @(negedge clk);
        rstn = 1'b1;
        do_req(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL dropped_write: got %h want 0", rd);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        exp_err;
        logic [31:0] exp_word;
`ifdef MEM_MISALIGN_ERR_EN
        exp_err  = 1'b1;
        exp_word = 32'h0;
`else
        exp_err  = 1'b0;
        exp_word = 32'hFFFFFFFF;
`endif
        do_req(1'b1, 32'h42, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        checks++;
        if (er !== exp_err || rd !== 32'd0 || lat !== 3) begin
            errors++;
            $display("FAIL misalign_rsp: err=%b rdata=%h lat=%0d want %b/0/3",
                     er, rd, lat, exp_err);
        end
        do_req(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== exp_word || er !== 1'b0) begin
            errors++;
            $display("FAIL misalign_word: rdata=%h err=%b want %h/0", rd, er, exp_word);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_wstrb = 4'h0;
        rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_partial_write();
        test_backpressure();
        test_wrap_zero_wait();
        test_reset_mid_wait();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
